// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding
// and counter sizing.
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH = 4;
  localparam int CNT_W     = $clog2(DIV_WIDTH + 1);

  // Counter width for an arbitrary operand width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/addsub_nbit.sv
// Parameterised ripple adder/subtractor: sum = a + (b ^ {N{sub}}) + sub.
// Built as a chain of full-adder cells; carry out of the top cell is not needed.
module addsub_nbit #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum
);

  logic [N-1:0] b_x;
  logic [N-1:0] carry;

  assign b_x      = b ^ {N{sub}};
  assign carry[0] = sub;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i] = a[i] ^ b_x[i] ^ carry[i];
    if (i < N - 1) begin : g_carry
      assign carry[i+1] = (a[i] & b_x[i]) | (a[i] & carry[i]) | (b_x[i] & carry[i]);
    end
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Multicycle unsigned restoring divider: one trial subtract per clock,
// start/done handshake, results and status held in registered outputs.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dvz
);

  localparam int CW = cnt_width(WIDTH);

  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dvz_q, dvz_d;

  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   diff;
  logic             qbit;

  // A restored partial remainder is always below the divisor, so the top bit
  // of the WIDTH+1-bit P is always zero and only the low WIDTH bits are kept.
  assign p_shift = {p_q, a_q[WIDTH-1]};

  addsub_nbit #(.N(WIDTH + 1)) u_addsub (
    .a   (p_shift),
    .b   ({1'b0, dvs_q}),
    .sub (1'b1),
    .sum (diff)
  );

  assign qbit = ~diff[WIDTH];

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    a_d     = a_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvz_d   = dvz_q;
    busy_d  = (state_q == ST_RUN);
    done_d  = (state_q == ST_DONE);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (state_q == ST_DONE) begin
          quo_d = a_q;
          rem_d = p_q;
        end
        if (start) begin
          p_d     = '0;
          a_d     = dividend;
          dvs_d   = divisor;
          cnt_d   = '0;
          dvz_d   = (divisor == '0);
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        p_d   = qbit ? diff[WIDTH-1:0] : p_shift[WIDTH-1:0];
        a_d   = {a_q[WIDTH-2:0], qbit};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      p_q     <= '0;
      a_q     <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      a_q     <= a_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvz_q   <= dvz_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign dvz       = dvz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider at WIDTH=4: latency,
// directed corner cases, handshake/reset behaviour, exhaustive and random sweeps.
module tb_seq_restoring_divider;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         dvz;

  int total;
  int bad;

  // Expected result packed as {dvz, quotient, remainder}.
  logic [2*W:0] exp_q[$];

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dvz       (dvz)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return {1'b1, {W{1'b1}}, a};
    return {1'b0, W'(a / b), W'(a % b)};
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [2*W:0] e;
    if (!rst && done) begin
      check("busy_done_excl", 16'(busy), 16'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 16'd1, 16'd0);
      end else begin
        e = exp_q.pop_front();
        check("quotient",  16'(quotient),  16'(e[2*W-1:W]));
        check("remainder", 16'(remainder), 16'(e[W-1:0]));
        check("dvz",       16'(dvz),       16'(e[2*W]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) return;
    end
    check("done_timeout", 16'd0, 16'd1);
  endtask

  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b, input bit expect_result);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    if (expect_result) exp_q.push_back(model(a, b));
    @(negedge clk);
    start    = 1'b0;
    dividend = W'($urandom_range(0, 15));
    divisor  = W'($urandom_range(0, 15));
  endtask

  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    drive_start(a, b, 1'b1);
    wait_done();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int busy_cnt;
    int done_at;
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_quo",  16'(quotient), 16'd0);
    check("rst_rem",  16'(remainder), 16'd0);
    check("rst_dvz",  16'(dvz), 16'd0);
    rst = 1'b0;

    // Latency: 13/3, done 5 negedges after the accept edge, busy for 4 cycles.
    @(negedge clk);
    drive_start(4'd13, 4'd3, 1'b1);
    check("busy_after_accept", 16'(busy), 16'd0);
    busy_cnt = 0;
    done_at  = -1;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done && done_at < 0) done_at = j;
    end
    check("done_latency", 16'(done_at), 16'd5);
    check("busy_cycles",  16'(busy_cnt), 16'd4);

    // Directed corner cases.
    do_div(4'd15, 4'd15);
    do_div(4'd15, 4'd1);
    do_div(4'd3,  4'd5);
    do_div(4'd0,  4'd7);
    do_div(4'd5,  4'd0);
    do_div(4'd9,  4'd2);

    // start mid-RUN is ignored; start during the done cycle is accepted.
    @(negedge clk);
    drive_start(4'd13, 4'd3, 1'b1);
    @(negedge clk);
    @(negedge clk);
    drive_start(4'd14, 4'd9, 1'b0);
    wait_done();
    drive_start(4'd14, 4'd9, 1'b1);
    wait_done();

    // Reset during the second RUN cycle aborts the operation.
    @(negedge clk);
    drive_start(4'd13, 4'd3, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 16'(busy), 16'd0);
    check("abort_done", 16'(done), 16'd0);
    check("abort_quo",  16'(quotient), 16'd0);
    check("abort_rem",  16'(remainder), 16'd0);
    check("abort_dvz",  16'(dvz), 16'd0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    do_div(4'd13, 4'd3);

    // Exhaustive sweep of all operand pairs.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_div(W'(a), W'(b));
      end
    end

    // Random back-to-back: each new start issued in the done cycle.
    @(negedge clk);
    drive_start(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), 1'b1);
    for (int n = 0; n < 40; n++) begin
      wait_done();
      drive_start(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), 1'b1);
    end
    wait_done();

    repeat (3) @(negedge clk);
    check("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
